// File: rtl/sext_arbiter_if.sv
// Handshake bundle between the decode-stage requesters, the response consumer and the shared sign extender.
// Define SEXT_ARB_ZEXT_EN to add the per-request zero-extend qualifiers.
interface sext_arbiter_if #(
    parameter int IMM_W  = 14,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic [IMM_W-1:0]  req0_imm;
    logic              req0_ready;
    logic              req1_valid;
    logic [IMM_W-1:0]  req1_imm;
    logic              req1_ready;
`ifdef SEXT_ARB_ZEXT_EN
    logic              req0_zext;
    logic              req1_zext;
`endif
    logic [IMM_W-1:0]  sext_in;
    logic [DATA_W-1:0] sext_out;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_ready;

    // master: requesters, consumer and extender; slave: the arbiter
    modport master (
`ifdef SEXT_ARB_ZEXT_EN
        output req0_zext, req1_zext,
`endif
        output req0_valid, req0_imm, req1_valid, req1_imm, sext_out, rsp_ready,
        input  req0_ready, req1_ready, sext_in, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
`ifdef SEXT_ARB_ZEXT_EN
        input  req0_zext, req1_zext,
`endif
        input  req0_valid, req0_imm, req1_valid, req1_imm, sext_out, rsp_ready,
        output req0_ready, req1_ready, sext_in, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/sext_arbiter.sv
// Round-robin arbiter sharing one sign-extension unit between the branch-offset (0) and ALU-immediate (1) paths.
// Optional SEXT_ARB_ZEXT_EN: requests flagged zext load the zero-extended immediate instead of sext_out.
module sext_arbiter #(
    parameter int IMM_W  = 14,
    parameter int DATA_W = 16
) (
    input logic          clk,
    input logic          reset,
    sext_arbiter_if.slave bus
);
    // state | meaning
    // EMPTY | response register holds nothing, any request may be granted
    // FULL  | response register holds a result; a grant needs rsp_ready this cycle
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int EXT_W = DATA_W - IMM_W;

    state_t            state_q, state_d;
    logic              last_q;
    logic              grant0, grant1, any_grant, can_accept;
    logic [IMM_W-1:0]  grant_imm, hold_q;
    logic [DATA_W-1:0] load_data, rsp_data_q;
    logic              rsp_id_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            last_q     <= 1'b1;
            hold_q     <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (any_grant) begin
                last_q     <= grant1;
                hold_q     <= grant_imm;
                rsp_data_q <= load_data;
                rsp_id_q   <= grant1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        can_accept = (state_q == EMPTY) || bus.rsp_ready;
        // last_q=1 means requester 1 won last, so requester 0 wins a tie
        if (!reset && can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        any_grant = grant0 || grant1;
        if (any_grant) begin
            state_d = FULL;
        end else if (state_q == FULL && bus.rsp_ready) begin
            state_d = EMPTY;
        end
        grant_imm = grant1 ? bus.req1_imm : bus.req0_imm;
        load_data = bus.sext_out;
`ifdef SEXT_ARB_ZEXT_EN
        if ((grant0 && bus.req0_zext) || (grant1 && bus.req1_zext)) begin
            load_data = {{EXT_W{1'b0}}, grant_imm};
        end
`endif
    end

    // sext_in parks on the last granted operand so the extender input does not toggle when idle
    assign bus.sext_in    = any_grant ? grant_imm : hold_q;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
endmodule

// File: tb/tb_sext_arbiter.sv
// Self-checking bench for sext_arbiter: vector table for grants plus a response scoreboard.
// Build with SEXT_ARB_ZEXT_EN defined to also exercise the zero-extend path.
module tb_sext_arbiter;
    localparam int IMM_W  = 14;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic z0 = 1'b0;
    logic z1 = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              id;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic             v0;
        logic [IMM_W-1:0] i0;
        logic             v1;
        logic [IMM_W-1:0] i1;
        logic             rdy;
        logic             r0;
        logic             r1;
        logic             rv;
    } vec_t;
    vec_t vecs[16];

    logic [IMM_W-1:0] exp_hold;

    sext_arbiter_if #(.IMM_W(IMM_W), .DATA_W(DATA_W)) ifc ();

    sext_arbiter #(.IMM_W(IMM_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // behavioural model of the shared extender
    assign ifc.sext_out = {{(DATA_W-IMM_W){ifc.sext_in[IMM_W-1]}}, ifc.sext_in};

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ext(input logic [IMM_W-1:0] x, input logic z);
        if (z) return {{(DATA_W-IMM_W){1'b0}}, x};
        return {{(DATA_W-IMM_W){x[IMM_W-1]}}, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge: drive, check combinational outputs, update scoreboard, advance one cycle.
    task automatic step(input string tag, input logic rst,
                        input logic v0, input logic [IMM_W-1:0] i0,
                        input logic v1, input logic [IMM_W-1:0] i1,
                        input logic rdy, input logic r0, input logic r1, input logic rv);
        logic zz0, zz1;
        reset          = rst;
        ifc.req0_valid = v0;
        ifc.req0_imm   = i0;
        ifc.req1_valid = v1;
        ifc.req1_imm   = i1;
        ifc.rsp_ready  = rdy;
`ifdef SEXT_ARB_ZEXT_EN
        ifc.req0_zext  = z0;
        ifc.req1_zext  = z1;
        zz0 = z0;
        zz1 = z1;
`else
        zz0 = 1'b0;
        zz1 = 1'b0;
`endif
        #1;
        chk({tag, " req0_ready"}, 32'(ifc.req0_ready), 32'(r0));
        chk({tag, " req1_ready"}, 32'(ifc.req1_ready), 32'(r1));
        chk({tag, " rsp_valid"},  32'(ifc.rsp_valid),  32'(rv));
        if (rv) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s rsp_q: got a pending response expected none", tag);
            end else begin
                chk({tag, " rsp_data"}, 32'(ifc.rsp_data), 32'(sb[0].data));
                chk({tag, " rsp_id"},   32'(ifc.rsp_id),   32'(sb[0].id));
            end
        end
        if (r0)      chk({tag, " sext_in"}, 32'(ifc.sext_in), 32'(i0));
        else if (r1) chk({tag, " sext_in"}, 32'(ifc.sext_in), 32'(i1));
        else         chk({tag, " sext_in"}, 32'(ifc.sext_in), 32'(exp_hold));
        if (rst) begin
            sb.delete();
            exp_hold = '0;
        end else begin
            if (rv && rdy && sb.size() != 0) void'(sb.pop_front());
            if (r0) begin
                sb.push_back('{data: ext(i0, zz0), id: 1'b0});
                exp_hold = i0;
            end
            if (r1) begin
                sb.push_back('{data: ext(i1, zz1), id: 1'b1});
                exp_hold = i1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        //          v0  i0          v1  i1          rdy   r0    r1    rv
        vecs[0]  = '{1'b0, 14'h3C3C, 1'b0, 14'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 14'h0FFF, 1'b0, 14'h1234, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 14'h2222, 1'b1, 14'h3FFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 14'h0000, 1'b1, 14'h2000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 14'h0123, 1'b1, 14'h3456, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 14'h0AAA, 1'b1, 14'h2BBB, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 14'h1111, 1'b1, 14'h2222, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 14'h1111, 1'b1, 14'h2222, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 14'h1111, 1'b1, 14'h2222, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 14'h1111, 1'b1, 14'h2222, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 14'h1111, 1'b1, 14'h2222, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

        exp_hold       = '0;
        reset          = 1'b1;
        ifc.req0_valid = 1'b0;
        ifc.req0_imm   = '0;
        ifc.req1_valid = 1'b0;
        ifc.req1_imm   = '0;
        ifc.rsp_ready  = 1'b0;
`ifdef SEXT_ARB_ZEXT_EN
        ifc.req0_zext  = 1'b0;
        ifc.req1_zext  = 1'b0;
`endif
        @(negedge clk);
        step("reset", 1'b1, 1'b1, 14'h1555, 1'b1, 14'h2AAA, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("row%0d", i), 1'b0, vecs[i].v0, vecs[i].i0, vecs[i].v1, vecs[i].i1,
                 vecs[i].rdy, vecs[i].r0, vecs[i].r1, vecs[i].rv);
        end

        // reset while FULL after a requester-0 grant: response dropped, priority back to 0
        step("mid_fill",  1'b0, 1'b1, 14'h0555, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mid_hold",  1'b0, 1'b1, 14'h0666, 1'b1, 14'h0777, 1'b0, 1'b0, 1'b0, 1'b1);
        step("mid_reset", 1'b1, 1'b1, 14'h0666, 1'b1, 14'h0777, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rr0", 1'b0, 1'b1, 14'h0888, 1'b1, 14'h0999, 1'b1, 1'b1, 1'b0, 1'b0);
        step("rr1", 1'b0, 1'b1, 14'h0888, 1'b1, 14'h3999, 1'b1, 1'b0, 1'b1, 1'b1);
        step("rr2", 1'b0, 1'b1, 14'h2888, 1'b1, 14'h0999, 1'b1, 1'b1, 1'b0, 1'b1);
        step("rr3", 1'b0, 1'b1, 14'h0888, 1'b1, 14'h1999, 1'b1, 1'b0, 1'b1, 1'b1);
        step("drain", 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step("idle",  1'b0, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SEXT_ARB_ZEXT_EN
        z0 = 1'b1;
        step("zext1", 1'b0, 1'b1, 14'h3FFF, 1'b0, 14'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        z0 = 1'b0;
        step("zext0", 1'b0, 1'b1, 14'h3FFF, 1'b0, 14'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        z1 = 1'b1;
        step("zext_r1", 1'b0, 1'b0, 14'h0000, 1'b1, 14'h2001, 1'b1, 1'b0, 1'b1, 1'b1);
        z1 = 1'b0;
        step("zdrain", 1'b0, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        step("zidle",  1'b0, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
